// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx between N_REQ byte requesters and times each frame locally.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CLK_DIV   = 57,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GUARD     = 8
) (
  input  logic               sys_clk_100M,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               tx_ready,
  output logic [7:0]         tx_data
);

  localparam int unsigned TOcc     = PULSE_LEN + 10 * CLK_DIV + GUARD;
  localparam logic [15:0] PulseEnd = 16'(PULSE_LEN - 1);
  localparam logic [15:0] OccEnd   = 16'(TOcc - 1);

  if (TOcc > 65535) begin : gen_tocc_chk
    $error("uart_tx_arb: frame occupancy time does not fit the 16-bit counter");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : gen_nreq_chk
    $error("uart_tx_arb: N_REQ must be in 2..8");
  end
  if (PULSE_LEN < 3) begin : gen_pulse_chk
    $error("uart_tx_arb: PULSE_LEN must be at least 3");
  end

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e             state_q;
  logic [15:0]        occ_cnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic [2:0]         grant_id_q;
  logic               busy_q;
  logic               tx_ready_q;
  logic [7:0]         tx_data_q;

  logic [2:0]         win_id;
  logic               win_vld;
  logic [7:0]         win_data;
  logic [7:0]         req_pad;
  logic [63:0]        data_pad;

  // Padded copies let a 3-bit index address any requester without width mismatches.
  assign req_pad  = 8'(req);
  assign data_pad = 64'(req_data);
  assign win_data = data_pad[{win_id, 3'b000} +: 8];

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_pad[i]) begin
        win_id  = 3'(i);
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [2:0] rr_ptr_q;
  logic [3:0] cand;

  // Search starts just after the last winner, so it ends up with lowest priority.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 4'(rr_ptr_q) + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!win_vld && req_pad[cand[2:0]]) begin
        win_id  = cand[2:0];
        win_vld = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      state_q    <= StIdle;
      occ_cnt_q  <= '0;
      ack_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= 3'(N_REQ - 1);
`endif
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_vld) begin
            tx_data_q  <= win_data;
            grant_id_q <= win_id;
            ack_q      <= N_REQ'(1) << win_id;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= win_id;
`endif
            occ_cnt_q  <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          occ_cnt_q <= occ_cnt_q + 16'd1;
          if (occ_cnt_q == PulseEnd) begin
            tx_ready_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          // uart_tx has no busy flag; ownership ends only when the local frame timer expires.
          occ_cnt_q <= occ_cnt_q + 16'd1;
          if (occ_cnt_q == OccEnd) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign tx_ready = tx_ready_q;
  assign tx_data  = tx_data_q;

endmodule
